// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - HI/LO owner and sequencer for the shared iterative multiplier/divider
module muldiv_sequencer #(
    parameter int TIMEOUT_CYCLES = 40,
    parameter int CNT_W          = 6
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cmd_valid,
    input  logic [2:0]  cmd_op,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        busy,
    output logic        done,
    output logic        div_zero,
    output logic        timeout,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] unit_a,
    output logic [31:0] unit_b,
    output logic        mul_start,
    output logic        div_start,
    output logic        unit_reset,
    input  logic        mul_done,
    input  logic [31:0] mul_hi,
    input  logic [31:0] mul_lo,
    input  logic        div_done,
    input  logic [31:0] div_rem,
    input  logic [31:0] div_quo
);
    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_MUL, WAIT_DIV} state_t;

    localparam logic [2:0]       OP_MULT  = 3'd1;
    localparam logic [2:0]       OP_DIV   = 3'd2;
    localparam logic [2:0]       OP_MTHI  = 3'd3;
    localparam logic [2:0]       OP_MTLO  = 3'd4;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t            state;
    logic              target_div;
    logic [CNT_W-1:0]  cnt;
    logic              accept;

    assign accept     = cmd_valid && !busy && (state == IDLE);
    // Units are held in reset for the cycle after an abort so a hung unit starts clean.
    assign unit_reset = reset | timeout;

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            target_div <= 1'b0;
            cnt        <= '0;
            hi         <= '0;
            lo         <= '0;
            unit_a     <= '0;
            unit_b     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            div_zero   <= 1'b0;
            timeout    <= 1'b0;
            mul_start  <= 1'b0;
            div_start  <= 1'b0;
        end else begin
            done      <= 1'b0;
            div_zero  <= 1'b0;
            timeout   <= 1'b0;
            mul_start <= 1'b0;
            div_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        case (cmd_op)
                            OP_MULT: begin
                                unit_a     <= op_a;
                                unit_b     <= op_b;
                                target_div <= 1'b0;
                                mul_start  <= 1'b1;
                                busy       <= 1'b1;
                                state      <= LAUNCH;
                            end
                            OP_DIV: begin
                                if (op_b == '0) begin
                                    div_zero <= 1'b1;
                                end else begin
                                    unit_a     <= op_a;
                                    unit_b     <= op_b;
                                    target_div <= 1'b1;
                                    div_start  <= 1'b1;
                                    busy       <= 1'b1;
                                    state      <= LAUNCH;
                                end
                            end
                            OP_MTHI: hi <= op_a;
                            OP_MTLO: lo <= op_a;
                            default: ;
                        endcase
                    end
                end
                LAUNCH: begin
                    cnt   <= '0;
                    state <= target_div ? WAIT_DIV : WAIT_MUL;
                end
                WAIT_MUL, WAIT_DIV: begin
                    cnt <= cnt + 1'b1;
                    if (state == WAIT_MUL && mul_done) begin
                        hi    <= mul_hi;
                        lo    <= mul_lo;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (state == WAIT_DIV && div_done) begin
                        hi    <= div_rem;
                        lo    <= div_quo;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (cnt == CNT_LAST) begin
                        timeout <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - directed vector bench for muldiv_sequencer with behavioural mul/div units
module tb_muldiv_sequencer;
    logic        clock = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic [2:0]  cmd_op;
    logic [31:0] op_a, op_b;
    logic        busy, done, div_zero, timeout;
    logic [31:0] hi, lo, unit_a, unit_b;
    logic        mul_start, div_start, unit_reset;
    logic        mul_done, div_done;
    logic [31:0] mul_hi, mul_lo, div_rem, div_quo;

    always #5 clock = ~clock;

    muldiv_sequencer #(.TIMEOUT_CYCLES(40), .CNT_W(6)) dut (
        .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
        .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .div_zero(div_zero),
        .timeout(timeout), .hi(hi), .lo(lo), .unit_a(unit_a), .unit_b(unit_b),
        .mul_start(mul_start), .div_start(div_start), .unit_reset(unit_reset),
        .mul_done(mul_done), .mul_hi(mul_hi), .mul_lo(mul_lo),
        .div_done(div_done), .div_rem(div_rem), .div_quo(div_quo)
    );

    // Behavioural units: done pulses <lat> cycles after the start pulse is seen.
    int          mul_lat = 1, div_lat = 1;
    logic        mul_en = 1'b1, inject_mul = 1'b0;
    int          mcnt = 0, dcnt = 0;
    logic [63:0] prod;
    logic [31:0] q, r;

    initial begin
        mul_done = 1'b0; div_done = 1'b0;
        mul_hi = '0; mul_lo = '0; div_rem = '0; div_quo = '0;
        forever begin
            @(posedge clock);
            #2;
            mul_done = 1'b0;
            div_done = 1'b0;
            if (unit_reset) begin
                mcnt = 0;
                dcnt = 0;
            end else begin
                if (inject_mul) begin
                    mul_done = 1'b1;
                    mul_hi   = 32'hAAAA5555;
                    mul_lo   = 32'h5555AAAA;
                end
                if (mcnt != 0) begin
                    mcnt--;
                    if (mcnt == 0 && mul_en) begin
                        mul_done = 1'b1;
                        {mul_hi, mul_lo} = prod;
                    end
                end
                if (dcnt != 0) begin
                    dcnt--;
                    if (dcnt == 0) begin
                        div_done = 1'b1;
                        div_rem  = r;
                        div_quo  = q;
                    end
                end
                if (mul_start) begin
                    mcnt = mul_lat;
                    prod = $signed({{32{unit_a[31]}}, unit_a}) * $signed({{32{unit_b[31]}}, unit_b});
                end
                if (div_start) begin
                    dcnt = div_lat;
                    q = $signed(unit_a) / $signed(unit_b);
                    r = $signed(unit_a) % $signed(unit_b);
                end
            end
        end
    end

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a, b;
        int          lat;
        logic [31:0] exp_hi, exp_lo;
        int          n_done, n_dz, n_ms, n_ds, busy_cyc;
    } vec_t;

    vec_t vecs[10];
    int n_vec = 0, n_bad = 0;
    int c_done, c_dz, c_ms, c_ds, c_to, c_busy;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_counts();
        c_done = 0; c_dz = 0; c_ms = 0; c_ds = 0; c_to = 0; c_busy = 0;
    endtask

    task automatic observe();
        c_done += int'(done);
        c_dz   += int'(div_zero);
        c_ms   += int'(mul_start);
        c_ds   += int'(div_start);
        c_to   += int'(timeout);
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        cmd_valid = 1'b1; cmd_op = op; op_a = a; op_b = b;
        step();
        cmd_valid = 1'b0; cmd_op = 3'd0;
    endtask

    // Observes from the cycle after accept until busy falls, then one more cycle for pulse width.
    task automatic run_to_idle(input string tag);
        int guard = 0;
        while (1) begin
            observe();
            if (!busy) break;
            c_busy++;
            guard++;
            if (guard > 200) begin
                chk({tag, "_busy_bound"}, 32'(busy), 32'd0);
                break;
            end
            step();
        end
        step();
        observe();
    endtask

    task automatic run_vec(input int i);
        string t;
        t = $sformatf("v%0d", i);
        mul_lat = vecs[i].lat;
        div_lat = vecs[i].lat;
        clear_counts();
        issue(vecs[i].op, vecs[i].a, vecs[i].b);
        run_to_idle(t);
        chk({t, "_hi"}, hi, vecs[i].exp_hi);
        chk({t, "_lo"}, lo, vecs[i].exp_lo);
        chk({t, "_done"}, 32'(c_done), 32'(vecs[i].n_done));
        chk({t, "_divzero"}, 32'(c_dz), 32'(vecs[i].n_dz));
        chk({t, "_mulstart"}, 32'(c_ms), 32'(vecs[i].n_ms));
        chk({t, "_divstart"}, 32'(c_ds), 32'(vecs[i].n_ds));
        chk({t, "_busycyc"}, 32'(c_busy), 32'(vecs[i].busy_cyc));
        chk({t, "_timeout"}, 32'(c_to), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k;
        vecs[0] = '{3'd1, 32'd7, 32'hFFFFFFFD, 33, 32'hFFFFFFFF, 32'hFFFFFFEB, 1, 0, 1, 0, 34};
        vecs[1] = '{3'd2, 32'd100, 32'd7, 33, 32'd2, 32'd14, 1, 0, 0, 1, 34};
        vecs[2] = '{3'd2, 32'd5, 32'd0, 5, 32'd2, 32'd14, 0, 1, 0, 0, 0};
        vecs[3] = '{3'd3, 32'h12345678, 32'd0, 1, 32'h12345678, 32'd14, 0, 0, 0, 0, 0};
        vecs[4] = '{3'd4, 32'h9ABCDEF0, 32'd0, 1, 32'h12345678, 32'h9ABCDEF0, 0, 0, 0, 0, 0};
        vecs[5] = '{3'd0, 32'hFFFFFFFF, 32'd3, 1, 32'h12345678, 32'h9ABCDEF0, 0, 0, 0, 0, 0};
        vecs[6] = '{3'd7, 32'hFFFFFFFF, 32'd3, 1, 32'h12345678, 32'h9ABCDEF0, 0, 0, 0, 0, 0};
        vecs[7] = '{3'd1, 32'h00010000, 32'h00010000, 5, 32'd1, 32'd0, 1, 0, 1, 0, 6};
        vecs[8] = '{3'd2, 32'hFFFFFFF9, 32'd2, 3, 32'hFFFFFFFF, 32'hFFFFFFFD, 1, 0, 0, 1, 4};
        vecs[9] = '{3'd1, 32'd3, 32'd4, 1, 32'd0, 32'd12, 1, 0, 1, 0, 2};

        reset = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; op_a = '0; op_b = '0;
        step();
        step();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_unit_a", unit_a, 32'd0);
        chk("rst_pulses", {28'd0, done, div_zero, timeout, mul_start}, 32'd0);
        chk("rst_unit_reset", 32'(unit_reset), 32'd1);
        reset = 1'b0;
        step();
        chk("post_rst_unit_reset", 32'(unit_reset), 32'd0);

        for (int i = 0; i < 10; i++) run_vec(i);

        // Back-to-back MTHI then MTLO.
        cmd_valid = 1'b1; cmd_op = 3'd3; op_a = 32'hCAFEF00D;
        step();
        chk("b2b_hi", hi, 32'hCAFEF00D);
        chk("b2b_busy0", 32'(busy), 32'd0);
        cmd_op = 3'd4; op_a = 32'h0BADBEEF;
        step();
        cmd_valid = 1'b0; cmd_op = 3'd0;
        chk("b2b_lo", lo, 32'h0BADBEEF);
        chk("b2b_busy1", 32'(busy), 32'd0);

        // MTHI presented while a MULT is busy must be ignored.
        mul_lat = 10;
        clear_counts();
        issue(3'd1, 32'd6, 32'd7);
        observe();
        cmd_valid = 1'b1; cmd_op = 3'd3; op_a = 32'hDEADDEAD;
        step();
        cmd_valid = 1'b0; cmd_op = 3'd0;
        run_to_idle("mthi_busy");
        chk("mthi_busy_hi", hi, 32'd0);
        chk("mthi_busy_lo", lo, 32'd42);
        chk("mthi_busy_done", 32'(c_done), 32'd1);

        // Hung multiplier: timeout 41 cycles after the start pulse (1 launch + 40 wait).
        mul_en = 1'b0;
        mul_lat = 33;
        issue(3'd1, 32'd9, 32'd9);
        chk("to_start", 32'(mul_start), 32'd1);
        k = 0;
        while (!timeout && k < 100) begin
            step();
            k++;
        end
        chk("to_cycles", 32'(k), 32'd41);
        chk("to_unit_reset", 32'(unit_reset), 32'd1);
        chk("to_busy", 32'(busy), 32'd0);
        chk("to_hi", hi, 32'd0);
        chk("to_lo", lo, 32'd42);
        chk("to_done", 32'(done), 32'd0);
        step();
        chk("to_pulse_width", 32'(timeout), 32'd0);
        chk("to_unit_reset_width", 32'(unit_reset), 32'd0);
        mul_en = 1'b1;

        mul_lat = 4;
        clear_counts();
        issue(3'd1, 32'd2, 32'd3);
        run_to_idle("after_to");
        chk("after_to_lo", lo, 32'd6);
        chk("after_to_done", 32'(c_done), 32'd1);
        chk("after_to_busycyc", 32'(c_busy), 32'd5);

        // Reset 10 cycles into a MULT, then a stray late mul_done.
        mul_lat = 33;
        issue(3'd1, 32'd3, 32'd5);
        repeat (10) step();
        reset = 1'b1;
        step();
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_hi", hi, 32'd0);
        chk("midrst_lo", lo, 32'd0);
        chk("midrst_unit_reset", 32'(unit_reset), 32'd1);
        reset = 1'b0;
        inject_mul = 1'b1;
        step();
        inject_mul = 1'b0;
        clear_counts();
        for (int i = 0; i < 5; i++) begin
            observe();
            c_busy += int'(busy);
            step();
        end
        chk("stray_done", 32'(c_done), 32'd0);
        chk("stray_busy", 32'(c_busy), 32'd0);
        chk("stray_hi", hi, 32'd0);
        chk("stray_lo", lo, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
Owns the architectural HI/LO registers of the multicycle MIPS core. Sequences the shared iterative multiplier and divider units on behalf of the control unit. Accepts one command at a time, launches the selected unit, and stalls the core via busy until results are written back. Also detects divide-by-zero and hung units (timeout).

Parameters:
TIMEOUT_CYCLES, 40, max cycles spent waiting for a unit's done before aborting; must exceed the unit's 34-cycle latency.
CNT_W, 6, width of the wait counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
clock  in  1  system clock
reset  in  1  synchronous active-high reset
cmd_valid  in  1  command request from control unit
cmd_op  in  3  0=NOP, 1=MULT, 2=DIV, 3=MTHI, 4=MTLO; 5-7 treated as NOP
op_a  in  32  rs operand (multiplicand / dividend / MTHI-MTLO data)
op_b  in  32  rt operand (multiplier / divisor)
busy  out  1  stall to control unit; commands ignored while high
done  out  1  one-cycle pulse: HI/LO updated by MULT/DIV
div_zero  out  1  one-cycle pulse: DIV with op_b==0 rejected
timeout  out  1  one-cycle pulse: unit failed to finish in time
hi  out  32  HI register (MFHI source)
lo  out  32  LO register (MFLO source)
unit_a  out  32  latched operand A to both units
unit_b  out  32  latched operand B to both units
mul_start  out  1  one-cycle start pulse to multiplier
div_start  out  1  one-cycle start pulse to divider
unit_reset  out  1  reset to both units (reset OR abort)
mul_done  in  1  multiplier result-valid pulse
mul_hi  in  32  multiplier high word
mul_lo  in  32  multiplier low word
div_done  in  1  divider result-valid pulse
div_rem  in  32  divider remainder
div_quo  in  32  divider quotient

Behaviour:
- Reset values: state IDLE; hi, lo, unit_a, unit_b = 0; busy, done, div_zero, timeout, mul_start, div_start = 0; wait counter = 0. unit_reset = 1 during reset.
- A command is accepted on a rising edge where cmd_valid=1, busy=0, and state=IDLE.
- FSM states: IDLE, LAUNCH, WAIT_MUL, WAIT_DIV.
- IDLE, on accept:
  - MULT: latch op_a/op_b into unit_a/unit_b; go to LAUNCH with target=MUL; busy=1 from the next cycle.
  - DIV, op_b!=0: latch operands; go to LAUNCH with target=DIV; busy=1.
  - DIV, op_b==0: stay in IDLE; div_zero pulses the next cycle; HI/LO unchanged; no start issued.
  - MTHI/MTLO: hi (or lo) <= op_a at the accept edge; stay in IDLE; busy stays 0; done not pulsed.
  - NOP/undefined: no effect.
- LAUNCH (exactly 1 cycle): mul_start or div_start is high for this cycle only, with operands stable. Clear the counter, then go to WAIT_MUL or WAIT_DIV.
- WAIT_x: counter increments each cycle.
  - On x_done=1: hi<=mul_hi / lo<=mul_lo (MUL), or hi<=div_rem / lo<=div_quo (DIV). Go to IDLE; done=1 next cycle; busy=0 next cycle.
  - If the counter reaches TIMEOUT_CYCLES with no done: go to IDLE; HI/LO unchanged; timeout=1 and unit_reset=1 for one cycle.
  - The done of the non-selected unit is ignored.
- Stray mul_done/div_done arriving while in IDLE or LAUNCH is ignored.
- busy is high in LAUNCH and WAIT_x, and low in IDLE. A command presented in the cycle busy falls is accepted at the next edge. HI/LO show the new values in that same cycle.
- Reset mid-operation: returns to IDLE in one edge and clears HI/LO. unit_reset=1 so the units discard in-flight work. Outputs reach reset values.
- unit_a/unit_b hold their last latched value outside LAUNCH/WAIT.
- Latency MULT/DIV: accept edge -> LAUNCH -> N unit cycles -> done-capture edge. Total = unit latency + 2 cycles of busy.

Test Plan:
- MULT op_a=7, op_b=0xFFFFFFFD (-3), multiplier model done after 33 cycles -> single mul_start pulse; busy high throughout; then hi=0xFFFFFFFF, lo=0xFFFFFFEB, done pulses once.
- DIV op_a=100, op_b=7 -> div_start once; on completion hi=2, lo=14; done pulses; mul_start never asserted.
- DIV op_a=5, op_b=0 -> div_zero pulses one cycle after accept; busy never rises; hi/lo unchanged; no start pulse.
- MTHI 0x12345678, then MTLO 0x9ABCDEF0 on consecutive cycles -> hi/lo updated each next cycle; busy stays 0. MTHI issued while busy during a MULT is ignored: hi equals the MULT result.
- Stubbed multiplier never asserts done -> timeout pulse after exactly TIMEOUT_CYCLES wait cycles; unit_reset pulses; busy drops; hi/lo keep prior values; next MULT executes normally.
- reset asserted 10 cycles into a MULT -> next cycle state IDLE, busy=0, hi=lo=0. A late mul_done pulse is ignored; no done pulse.
